parity_frame_controller: RTL and testbench

//  Receives serial frames (start bit, DATA_BITS data bits LSB first, parity bit, stop bit) one bit per bit_valid strobe.

---
 rtl/parity_frame_controller_pkg.sv | 21 ++
 rtl/parity_frame_controller_nibble_parity_check.sv | 14 +
 rtl/parity_frame_controller.sv | 128 ++++++++++++
 tb/tb_parity_frame_controller.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_frame_controller_pkg.sv
// Shared definitions for the parity frame controller: state encoding and
// default statistics counter width.
package parity_frame_controller_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DATA   = 3'd1;
    localparam logic [2:0] ST_PARITY = 3'd2;
    localparam logic [2:0] ST_STOP   = 3'd3;
    localparam logic [2:0] ST_HOLD   = 3'd4;

    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_DATA   = ST_DATA,
        S_PARITY = ST_PARITY,
        S_STOP   = ST_STOP,
        S_HOLD   = ST_HOLD
    } state_t;

endpackage

// File: rtl/parity_frame_controller_nibble_parity_check.sv
// Combinational parity checker: flags a mismatch between the data word,
// the received parity bit and the selected parity sense (odd=1 for odd).
module nibble_parity_check #(
    parameter int W = 4
) (
    input  logic [W-1:0] data,
    input  logic         parity,
    input  logic         odd,
    output logic         mismatch
);

    assign mismatch = ^data ^ parity ^ odd;

endmodule

// File: rtl/parity_frame_controller.sv
// Serial frame receiver: start bit, DATA_BITS data bits LSB first, parity
// bit, stop bit. The checked word is offered on a valid/ready port and
// error statistics are kept in saturating counters.
//
// Output handshake: out_valid rises the cycle after the stop-bit strobe and
// out_data/out_par_err/out_frm_err stay stable while out_valid is high; the
// word transfers on a cycle where out_valid && out_ready, and out_valid
// drops the following cycle.
module parity_frame_controller
    import parity_frame_controller_pkg::*;
#(
    parameter int DATA_BITS  = 4,
    parameter int PARITY_ODD = 0,
    parameter int CNT_W      = DEFAULT_CNT_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 bit_in,
    input  logic                 bit_valid,
    output logic [DATA_BITS-1:0] out_data,
    output logic                 out_par_err,
    output logic                 out_frm_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic [CNT_W-1:0]     par_err_cnt,
    output logic [CNT_W-1:0]     frm_err_cnt,
    output logic [CNT_W-1:0]     overrun_cnt,
    output logic [2:0]           state_dbg
);

    localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    state_t               state;
    state_t               state_nxt;
    logic [DATA_BITS-1:0] shreg;
    logic [IDX_W-1:0]     idx;
    logic                 par_bit;
    logic                 mismatch;
    logic                 accept;

    assign accept    = out_valid && out_ready;
    assign busy      = (state != S_IDLE);
    assign state_dbg = state;

    nibble_parity_check #(
        .W (DATA_BITS)
    ) u_parity (
        .data     (shreg),
        .parity   (par_bit),
        .odd      (1'(PARITY_ODD)),
        .mismatch (mismatch)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: every move is on a bit strobe except leaving HOLD,
    // which follows the output handshake.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (bit_valid && !bit_in)         state_nxt = S_DATA;
            S_DATA:   if (bit_valid && idx == LAST_IDX) state_nxt = S_PARITY;
            S_PARITY: if (bit_valid)                    state_nxt = S_STOP;
            S_STOP:   if (bit_valid)                    state_nxt = S_HOLD;
            S_HOLD:   if (accept)                       state_nxt = S_IDLE;
            default:                                    state_nxt = S_IDLE;
        endcase
    end

    // Datapath: shift register, parity latch, output register and
    // saturating statistics. Bits arriving in HOLD (including the accept
    // cycle) are dropped and counted as overruns.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shreg       <= '0;
            idx         <= '0;
            par_bit     <= 1'b0;
            out_data    <= '0;
            out_par_err <= 1'b0;
            out_frm_err <= 1'b0;
            out_valid   <= 1'b0;
            par_err_cnt <= '0;
            frm_err_cnt <= '0;
            overrun_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bit_valid && !bit_in) idx <= '0;
                end
                S_DATA: begin
                    if (bit_valid) begin
                        shreg[idx] <= bit_in;
                        idx        <= idx + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (bit_valid) par_bit <= bit_in;
                end
                S_STOP: begin
                    if (bit_valid) begin
                        out_data    <= shreg;
                        out_par_err <= mismatch;
                        out_frm_err <= ~bit_in;
                        out_valid   <= 1'b1;
                        if (mismatch && par_err_cnt != CNT_MAX)
                            par_err_cnt <= par_err_cnt + 1'b1;
                        if (!bit_in && frm_err_cnt != CNT_MAX)
                            frm_err_cnt <= frm_err_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (accept) out_valid <= 1'b0;
                    if (bit_valid && overrun_cnt != CNT_MAX)
                        overrun_cnt <= overrun_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_parity_frame_controller.sv
// Directed bench for parity_frame_controller. Three instances: default
// (even parity, 8-bit counters), a 2-bit counter copy for saturation, and
// an odd-parity copy. Bit strobes are steered to one instance via sel.
module tb_parity_frame_controller;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic bit_in = 1'b1;
    logic bit_valid = 1'b0;
    logic out_ready = 1'b1;
    int   sel = 0;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    logic bv_a, bv_s, bv_o;
    assign bv_a = bit_valid && (sel == 0);
    assign bv_s = bit_valid && (sel == 1);
    assign bv_o = bit_valid && (sel == 2);

    logic [3:0] data_a, data_s, data_o;
    logic       perr_a, perr_s, perr_o;
    logic       ferr_a, ferr_s, ferr_o;
    logic       vld_a, vld_s, vld_o;
    logic       busy_a, busy_s, busy_o;
    logic [7:0] pcnt_a, fcnt_a, ocnt_a;
    logic [1:0] pcnt_s, fcnt_s, ocnt_s;
    logic [7:0] pcnt_o, fcnt_o, ocnt_o;
    logic [2:0] st_a, st_s, st_o;

    parity_frame_controller #(.DATA_BITS(4), .PARITY_ODD(0), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bv_a),
        .out_data(data_a), .out_par_err(perr_a), .out_frm_err(ferr_a),
        .out_valid(vld_a), .out_ready(out_ready), .busy(busy_a),
        .par_err_cnt(pcnt_a), .frm_err_cnt(fcnt_a), .overrun_cnt(ocnt_a),
        .state_dbg(st_a));

    parity_frame_controller #(.DATA_BITS(4), .PARITY_ODD(0), .CNT_W(2)) dut_sat (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bv_s),
        .out_data(data_s), .out_par_err(perr_s), .out_frm_err(ferr_s),
        .out_valid(vld_s), .out_ready(out_ready), .busy(busy_s),
        .par_err_cnt(pcnt_s), .frm_err_cnt(fcnt_s), .overrun_cnt(ocnt_s),
        .state_dbg(st_s));

    parity_frame_controller #(.DATA_BITS(4), .PARITY_ODD(1), .CNT_W(8)) dut_odd (
        .clk(clk), .reset(reset), .bit_in(bit_in), .bit_valid(bv_o),
        .out_data(data_o), .out_par_err(perr_o), .out_frm_err(ferr_o),
        .out_valid(vld_o), .out_ready(out_ready), .busy(busy_o),
        .par_err_cnt(pcnt_o), .frm_err_cnt(fcnt_o), .overrun_cnt(ocnt_o),
        .state_dbg(st_o));

    // Called at posedge+1; returns at posedge+1 with the strobe consumed.
    task automatic send_bit(input logic b);
        bit_in = b;
        bit_valid = 1'b1;
        @(posedge clk); #1;
        bit_valid = 1'b0;
        bit_in = 1'b1;
    endtask

    task automatic send_frame(input logic [3:0] d, input logic p, input logic s);
        logic [3:0] dv;
        dv = d;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(dv[i]);
        send_bit(p);
        send_bit(s);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        n_checks++;
        if (vld_a !== 1'b0 || busy_a !== 1'b0 || data_a !== 4'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got vld=%b busy=%b data=%h, want 0 0 0", vld_a, busy_a, data_a);
        end
        n_checks++;
        if (pcnt_a !== 8'd0 || fcnt_a !== 8'd0 || ocnt_a !== 8'd0 || perr_a !== 1'b0 || ferr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_counters: got p=%0d f=%0d o=%0d pe=%b fe=%b, want all 0", pcnt_a, fcnt_a, ocnt_a, perr_a, ferr_a);
        end
        n_checks++;
        if (st_a !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_state: got %0d, want 0", st_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();
    endtask

    task automatic test_good_frame();
        int pulses;
        sel = 0;
        out_ready = 1'b1;
        send_bit(1'b1);  // idle-line bit is ignored
        n_checks++;
        if (busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_line_ignored: got busy=%b, want 0", busy_a);
        end
        send_bit(1'b0);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start: got %b, want 1", busy_a);
        end
        for (int i = 0; i < 4; i++) send_bit(i[0]);  // 0,1,0,1 -> 4'hA
        send_bit(1'b0);
        send_bit(1'b1);
        n_checks++;
        if (vld_a !== 1'b1 || data_a !== 4'hA || perr_a !== 1'b0 || ferr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL good_frame: got vld=%b data=%h pe=%b fe=%b, want 1 a 0 0", vld_a, data_a, perr_a, ferr_a);
        end
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (vld_a === 1'b1) pulses++;
            idle_cycle();
        end
        n_checks++;
        if (pulses !== 1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL good_frame_pulse: got pulses=%0d busy=%b, want 1 0", pulses, busy_a);
        end
    endtask

    task automatic test_parity_error();
        sel = 0;
        send_frame(4'hA, 1'b1, 1'b1);
        n_checks++;
        if (vld_a !== 1'b1 || data_a !== 4'hA || perr_a !== 1'b1 || ferr_a !== 1'b0 || pcnt_a !== 8'd1) begin
            n_fail++;
            $display("FAIL parity_error: got vld=%b data=%h pe=%b fe=%b pcnt=%0d, want 1 a 1 0 1", vld_a, data_a, perr_a, ferr_a, pcnt_a);
        end
        idle_cycle();
    endtask

    task automatic test_framing_error();
        sel = 0;
        send_frame(4'hA, 1'b0, 1'b0);
        n_checks++;
        if (vld_a !== 1'b1 || perr_a !== 1'b0 || ferr_a !== 1'b1 || fcnt_a !== 8'd1 || pcnt_a !== 8'd1) begin
            n_fail++;
            $display("FAIL framing_error: got vld=%b pe=%b fe=%b fcnt=%0d pcnt=%0d, want 1 0 1 1 1", vld_a, perr_a, ferr_a, fcnt_a, pcnt_a);
        end
        idle_cycle();
    endtask

    task automatic test_hold_overrun();
        int unstable;
        sel = 0;
        out_ready = 1'b0;
        send_frame(4'h3, 1'b0, 1'b1);
        unstable = 0;
        for (int i = 0; i < 5; i++) begin
            if (vld_a !== 1'b1 || data_a !== 4'h3 || perr_a !== 1'b0 || ferr_a !== 1'b0) unstable++;
            if (i % 2 == 0) send_bit(1'b0);
            else idle_cycle();
        end
        n_checks++;
        if (unstable !== 0 || vld_a !== 1'b1 || data_a !== 4'h3) begin
            n_fail++;
            $display("FAIL hold_stable: got unstable=%0d vld=%b data=%h, want 0 1 3", unstable, vld_a, data_a);
        end
        n_checks++;
        if (ocnt_a !== 8'd3) begin
            n_fail++;
            $display("FAIL overrun_cnt: got %0d, want 3", ocnt_a);
        end
        // Accept cycle carries a 0 strobe: counted as overrun, not a start bit.
        out_ready = 1'b1;
        send_bit(1'b0);
        n_checks++;
        if (vld_a !== 1'b0 || busy_a !== 1'b0 || ocnt_a !== 8'd4) begin
            n_fail++;
            $display("FAIL accept_cycle: got vld=%b busy=%b ocnt=%0d, want 0 0 4", vld_a, busy_a, ocnt_a);
        end
        send_frame(4'hC, 1'b0, 1'b1);
        n_checks++;
        if (vld_a !== 1'b1 || data_a !== 4'hC || perr_a !== 1'b0 || ferr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL after_hold_frame: got vld=%b data=%h pe=%b fe=%b, want 1 c 0 0", vld_a, data_a, perr_a, ferr_a);
        end
        idle_cycle();
    endtask

    task automatic test_back_to_back();
        // Next start bit one cycle after the accept cycle.
        sel = 0;
        out_ready = 1'b1;
        send_frame(4'h6, 1'b0, 1'b1);
        idle_cycle();
        send_frame(4'h9, 1'b0, 1'b1);
        n_checks++;
        if (vld_a !== 1'b1 || data_a !== 4'h9 || perr_a !== 1'b0 || ocnt_a !== 8'd4) begin
            n_fail++;
            $display("FAIL back_to_back: got vld=%b data=%h pe=%b ocnt=%0d, want 1 9 0 4", vld_a, data_a, perr_a, ocnt_a);
        end
        idle_cycle();
    endtask

    task automatic test_saturation();
        logic [1:0] exp_cnt;
        int bad;
        sel = 1;
        out_ready = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            send_frame(4'hA, 1'b1, 1'b1);
            exp_cnt = (i >= 2) ? 2'd3 : 2'(i + 1);
            if (pcnt_s !== exp_cnt || perr_s !== 1'b1) begin
                bad++;
                $display("FAIL sat_step%0d: got pcnt=%0d pe=%b, want %0d 1", i, pcnt_s, perr_s, exp_cnt);
            end
            idle_cycle();
        end
        n_checks++;
        if (bad !== 0 || pcnt_s !== 2'd3) begin
            n_fail++;
            $display("FAIL saturation: got pcnt=%0d bad_steps=%0d, want 3 0", pcnt_s, bad);
        end
    endtask

    task automatic test_odd_parity();
        sel = 2;
        out_ready = 1'b1;
        send_frame(4'hF, 1'b1, 1'b1);
        n_checks++;
        if (vld_o !== 1'b1 || data_o !== 4'hF || perr_o !== 1'b0 || pcnt_o !== 8'd0) begin
            n_fail++;
            $display("FAIL odd_good: got vld=%b data=%h pe=%b pcnt=%0d, want 1 f 0 0", vld_o, data_o, perr_o, pcnt_o);
        end
        idle_cycle();
        send_frame(4'hF, 1'b0, 1'b1);
        n_checks++;
        if (perr_o !== 1'b1 || pcnt_o !== 8'd1) begin
            n_fail++;
            $display("FAIL odd_bad: got pe=%b pcnt=%0d, want 1 1", perr_o, pcnt_o);
        end
        idle_cycle();
    endtask

    task automatic test_reset_mid_frame();
        sel = 0;
        // Reset while holding a word: out_valid drops without waiting for a clock.
        out_ready = 1'b0;
        send_frame(4'hA, 1'b1, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (vld_a !== 1'b0 || busy_a !== 1'b0 || pcnt_a !== 8'd0 || ocnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_in_hold: got vld=%b busy=%b pcnt=%0d ocnt=%0d, want 0 0 0 0", vld_a, busy_a, pcnt_a, ocnt_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        idle_cycle();
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        n_checks++;
        if (busy_a !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_mid_frame: got %b, want 1", busy_a);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if (busy_a !== 1'b0 || vld_a !== 1'b0 || fcnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL reset_mid_frame: got busy=%b vld=%b fcnt=%0d, want 0 0 0", busy_a, vld_a, fcnt_a);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        idle_cycle();
        send_frame(4'h5, 1'b0, 1'b1);
        n_checks++;
        if (vld_a !== 1'b1 || data_a !== 4'h5 || perr_a !== 1'b0 || ferr_a !== 1'b0 || pcnt_a !== 8'd0 || fcnt_a !== 8'd0) begin
            n_fail++;
            $display("FAIL clean_after_reset: got vld=%b data=%h pe=%b fe=%b pcnt=%0d fcnt=%0d, want 1 5 0 0 0 0",
                     vld_a, data_a, perr_a, ferr_a, pcnt_a, fcnt_a);
        end
        idle_cycle();
    endtask

    initial begin
        #1;
        test_reset();
        test_good_frame();
        test_parity_error();
        test_framing_error();
        test_hold_overrun();
        test_back_to_back();
        test_saturation();
        test_odd_parity();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
